uart_32bit_rx: RTL and testbench

Receive-side counterpart of the 32-bit UART transmitter. It deserialises 8N1 UART frames from the rx line and assembles four consecutive bytes into one 32-bit word. Byte order is LSB-first: byte 0 goes to [7:0] and byte 3 to [31:24], matching transmit order. The block sits between the external rx pin and the core's word-level consumer, e.g. the instruction/data loader.

---
 rtl/uart_32bit_rx.sv | 138 +++++++++++++
 tb/tb_uart_32bit_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_32bit_rx.sv
// rtl/uart_32bit_rx.sv - 8N1 UART receiver assembling four LSB-first bytes into a 32-bit word
module uart_32bit_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        timeout
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BW           = $clog2(CLKS_PER_BIT + 1);
  localparam int IW           = $clog2(TO_LIMIT + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TO_LIMIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [23:0]   word;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] idle_cnt;

  // Synchroniser idles high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      word       <= '0;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          // A start edge takes priority over an expiring inter-byte timeout.
          if (!rx_s) begin
            state    <= S_START;
            idle_cnt <= '0;
          end else if (byte_cnt != 2'd0) begin
            if (idle_cnt == IDLE_LAST) begin
              timeout  <= 1'b1;
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == BAUD_LAST) begin
            // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
            baud_cnt <= '0;
            state    <= S_IDLE;
            if (rx_s) begin
              case (byte_cnt)
                2'd0: word[7:0]   <= shift;
                2'd1: word[15:8]  <= shift;
                2'd2: word[23:16] <= shift;
                default: begin
                  data_out   <= {shift, word};
                  data_valid <= 1'b1;
                end
              endcase
              byte_cnt <= byte_cnt + 1'b1;
            end else begin
              frame_err <= 1'b1;
              byte_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_32bit_rx.sv
// tb/tb_uart_32bit_rx.sv - directed and randomized bench for uart_32bit_rx
module tb_uart_32bit_rx;

  localparam int CPB = 32;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        timeout;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int both_cnt = 0;
  int to_cyc = 0;
  int stop_cyc = 0;
  logic [31:0] words[$];

  uart_32bit_rx #(
    .CLK_FREQ(3200000),
    .BAUD(100000),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) words.push_back(data_out);
    if (frame_err) fe_cnt++;
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (data_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] exp[$]);
    check({tag, "_count"}, 32'(words.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < words.size(); i++)
      check($sformatf("%s_word%0d", tag, i), words[i], exp[i]);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    stop_cyc = cyc;
    if (bad_stop) begin
      rx = 1'b0;
      repeat (3 * CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB / 4) @(negedge clk);
    end else begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b0);
      idle_bits(gap);
    end
  endtask

  task automatic start_step();
    @(posedge clk);
    words.delete();
    fe_cnt = 0;
    to_cnt = 0;
    @(negedge clk);
  endtask

  logic [7:0]  part[$];
  logic [31:0] expq[$];
  logic [7:0]  rb;
  bit          bad;
  int          exp_fe;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b1;
    idle_bits(2);

    start_step();
    send_word(32'hDEADBEEF, 1);
    check_q("deadbeef", '{32'hDEADBEEF});
    check("deadbeef_fe", 32'(fe_cnt), 32'h0);
    check("deadbeef_to", 32'(to_cnt), 32'h0);

    start_step();
    send_word(32'h00000001, 0);
    send_word(32'hFFFFFFFF, 0);
    idle_bits(1);
    check_q("b2b", '{32'h00000001, 32'hFFFFFFFF});
    check("b2b_fe", 32'(fe_cnt), 32'h0);

    start_step();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    idle_bits(2);
    check("glitch_none", 32'(words.size()), 32'h0);
    send_word(32'h12345678, 1);
    check_q("glitch", '{32'h12345678});

    start_step();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    idle_bits(2);
    check("ferr_pulse", 32'(fe_cnt), 32'h1);
    check("ferr_hold", data_out, 32'h12345678);
    send_word(32'hCAFEBABE, 1);
    check_q("ferr", '{32'hCAFEBABE});
    check("ferr_total", 32'(fe_cnt), 32'h1);

    start_step();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    idle_bits(25);
    check("to_pulse", 32'(to_cnt), 32'h1);
    check("to_time", 32'((to_cyc >= stop_cyc + TOB * CPB) && (to_cyc <= stop_cyc + TOB * CPB + CPB)), 32'h1);
    check("to_hold", data_out, 32'hCAFEBABE);
    send_word(32'hA5A5A5A5, 1);
    check_q("to", '{32'hA5A5A5A5});
    check("to_total", 32'(to_cnt), 32'h1);

    start_step();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    check("mid_rst_to", 32'(timeout), 32'h0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    idle_bits(2);
    send_word(32'h0BADF00D, 1);
    check_q("rst", '{32'h0BADF00D});
    check("rst_fe", 32'(fe_cnt), 32'h0);

    start_step();
    exp_fe = 0;
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_byte(rb, bad);
      if (bad) begin
        part.delete();
        exp_fe++;
        idle_bits(1);
      end else begin
        part.push_back(rb);
        if (part.size() == 4) begin
          expq.push_back({part[3], part[2], part[1], part[0]});
          part.delete();
        end
      end
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(25);
    check_q("rand", expq);
    check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
    check("rand_to", 32'(to_cnt), 32'(part.size() != 0));
    check("never_both", 32'(both_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
